// File: rtl/axis_elastic_buffer.sv
// Multi-entry AXI-Stream elastic buffer carrying TDATA and TLAST, with registered
// valid/ready, a synchronous flush and an occupancy output.
module axis_elastic_buffer #(
    parameter int TDATA_WIDTH = 32,
    parameter int DEPTH       = 2,
    parameter int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [TDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [TDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   invalidate,
    output logic [CNT_WIDTH-1:0]   count
);

    localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_WIDTH = TDATA_WIDTH + 1;

    generate
        if (TDATA_WIDTH <= 0 || DEPTH < 2) begin : g_paramCheck
            $fatal(1, "axis_elastic_buffer: TDATA_WIDTH must be > 0 and DEPTH >= 2");
        end
    endgenerate

    logic [ENTRY_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]   r_wrPtr;
    logic [PTR_WIDTH-1:0]   r_rdPtr;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_mValid;
    logic                   r_sReady;

    logic                   w_push;
    logic                   w_pop;
    logic [CNT_WIDTH-1:0]   w_cntNext;
    logic [PTR_WIDTH-1:0]   w_wrPtrNext;
    logic [PTR_WIDTH-1:0]   w_rdPtrNext;
    logic [ENTRY_WIDTH-1:0] w_head;

    assign w_push = s_tvalid && r_sReady;
    assign w_pop  = r_mValid && m_tready;

    always_comb begin
        w_cntNext = r_cnt;
        if (w_push && !w_pop) begin
            w_cntNext = r_cnt + CNT_WIDTH'(1);
        end else if (!w_push && w_pop) begin
            w_cntNext = r_cnt - CNT_WIDTH'(1);
        end
    end

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    assign w_wrPtrNext = (r_wrPtr == PTR_WIDTH'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_WIDTH'(1);
    assign w_rdPtrNext = (r_rdPtr == PTR_WIDTH'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_WIDTH'(1);

    // Valid and ready are precomputed from the next occupancy so both handshake
    // outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_cnt    <= '0;
            r_mValid <= 1'b0;
            r_sReady <= 1'b0;
        end else if (invalidate) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_cnt    <= '0;
            r_mValid <= 1'b0;
            r_sReady <= 1'b1;
        end else begin
            if (w_push) begin
                r_wrPtr <= w_wrPtrNext;
            end
            if (w_pop) begin
                r_rdPtr <= w_rdPtrNext;
            end
            r_cnt    <= w_cntNext;
            r_mValid <= (w_cntNext != '0);
            r_sReady <= (w_cntNext < CNT_WIDTH'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !invalidate) begin
            r_mem[r_wrPtr] <= {s_tlast, s_tdata};
        end
    end

    assign w_head   = r_mem[r_rdPtr];
    assign m_tdata  = w_head[TDATA_WIDTH-1:0];
    assign m_tlast  = w_head[TDATA_WIDTH];
    assign m_tvalid = r_mValid;
    assign s_tready = r_sReady;
    assign count    = r_cnt;

endmodule

// File: tb/tb_axis_elastic_buffer.sv
// Scoreboard bench for axis_elastic_buffer: three instances (DEPTH 2, 3, 4) share
// one stimulus bus, and only the selected instance sees valid/ready/flush.
module tb_axis_elastic_buffer;

    logic        clk;
    logic        rst_n;
    logic        sValidBus;
    logic [31:0] sDataBus;
    logic        sLastBus;
    logic        mReadyBus;
    logic        invBus;
    int          sel;
    bit          monEn;

    logic [2:0]  sReadyV;
    logic [2:0]  mValidV;
    logic [2:0]  mLastV;
    logic [95:0] mDataV;
    logic [8:0]  countV;

    int checkCount;
    int errorCount;
    logic [32:0] expQ[$];
    bit          prevHold;
    logic [32:0] prevBeat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        localparam int D  = g + 2;
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] cntW;
        logic          sr;
        logic          mv;
        logic          ml;
        logic [31:0]   md;

        axis_elastic_buffer #(.TDATA_WIDTH(32), .DEPTH(D)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .s_tvalid  (sValidBus && (sel == g)),
            .s_tready  (sr),
            .s_tdata   (sDataBus),
            .s_tlast   (sLastBus),
            .m_tvalid  (mv),
            .m_tready  (mReadyBus && (sel == g)),
            .m_tdata   (md),
            .m_tlast   (ml),
            .invalidate(invBus && (sel == g)),
            .count     (cntW)
        );

        assign sReadyV[g]         = sr;
        assign mValidV[g]         = mv;
        assign mLastV[g]          = ml;
        assign mDataV[g*32 +: 32] = md;
        assign countV[g*3 +: 3]   = 3'(cntW);
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drive one beat and hold it until the selected instance accepts it.
    task automatic applyStimulus(input logic [31:0] d, input logic l, output int waits);
        bit ok;
        sDataBus  = d;
        sLastBus  = l;
        sValidBus = 1'b1;
        waits     = 0;
        forever begin
            @(negedge clk);
            ok = sReadyV[sel];
            @(posedge clk);
            #1;
            if (ok) break;
            waits++;
            if (waits > 200) begin
                checkOutput("sendTimeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic drain();
        int n;
        sValidBus = 1'b0;
        mReadyBus = 1'b1;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drainDone", 64'(expQ.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Occupancy/handshake model and in-order scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            prevHold = 1'b0;
        end else if (monEn) begin
            checkOutput("count", 64'(countV[sel*3 +: 3]), 64'(expQ.size()));
            checkOutput("mValid", 64'(mValidV[sel]), 64'(expQ.size() != 0));
            checkOutput("sReady", 64'(sReadyV[sel]), 64'(expQ.size() < sel + 2));
            if (prevHold) begin
                checkOutput("holdStable", 64'({mValidV[sel], mLastV[sel], mDataV[sel*32 +: 32]}),
                            64'({1'b1, prevBeat}));
            end
            if (mValidV[sel] && mReadyBus) begin
                if (expQ.size() == 0) begin
                    checkOutput("underflow", 64'({mLastV[sel], mDataV[sel*32 +: 32]}), 64'h1_DEAD_BEEF);
                end else begin
                    checkOutput("beat", 64'({mLastV[sel], mDataV[sel*32 +: 32]}), 64'(expQ.pop_front()));
                end
            end
            prevHold = mValidV[sel] && !mReadyBus && !invBus;
            prevBeat = {mLastV[sel], mDataV[sel*32 +: 32]};
            if (invBus) begin
                expQ.delete();
                prevHold = 1'b0;
            end else if (sValidBus && sReadyV[sel]) begin
                expQ.push_back({sLastBus, sDataBus});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  w;
        int  sent;
        bit  ok;
        checkCount = 0;
        errorCount = 0;
        sel        = 0;
        monEn      = 1'b0;
        sValidBus  = 1'b0;
        sDataBus   = '0;
        sLastBus   = 1'b0;
        mReadyBus  = 1'b0;
        invBus     = 1'b0;
        rst_n      = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            checkOutput("rstMValid", 64'(mValidV[g]), 64'd0);
            checkOutput("rstSReady", 64'(sReadyV[g]), 64'd0);
            checkOutput("rstCount", 64'(countV[g*3 +: 3]), 64'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            checkOutput("postRstSReady", 64'(sReadyV[g]), 64'd1);
        end
        monEn = 1'b1;

        $display("[TB] DEPTH=2 back-to-back with sink always ready");
        sel       = 0;
        mReadyBus = 1'b1;
        applyStimulus(32'h11, 1'b0, w);
        checkOutput("t1Wait0", 64'(w), 64'd0);
        checkOutput("t1Latency", 64'({mValidV[0], mDataV[31:0]}), 64'({1'b1, 32'h11}));
        applyStimulus(32'h22, 1'b0, w);
        checkOutput("t1Wait1", 64'(w), 64'd0);
        applyStimulus(32'h33, 1'b1, w);
        checkOutput("t1Wait2", 64'(w), 64'd0);
        drain();

        $display("[TB] DEPTH=4 fill with sink stalled");
        sel       = 2;
        mReadyBus = 1'b0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'hA0 + 32'(k), 1'b0, w);
            checkOutput("t2Wait", 64'(w), 64'd0);
        end
        checkOutput("t2FullSReady", 64'(sReadyV[2]), 64'd0);
        checkOutput("t2FullCount", 64'(countV[8:6]), 64'd4);
        sDataBus  = 32'hA4;
        sValidBus = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t2StillFull", 64'(countV[8:6]), 64'd4);
        mReadyBus = 1'b1;
        applyStimulus(32'hA4, 1'b0, w);
        applyStimulus(32'hA5, 1'b1, w);
        drain();

        $display("[TB] DEPTH=3 random traffic");
        sel       = 1;
        sent      = 0;
        sValidBus = 1'b0;
        for (int c = 0; c < 20000 && sent < 1000; c++) begin
            mReadyBus = 1'($urandom_range(0, 1));
            if (!sValidBus && $urandom_range(0, 1) == 1) begin
                sValidBus = 1'b1;
                sDataBus  = $urandom;
                sLastBus  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            ok = sValidBus && sReadyV[1];
            @(posedge clk);
            #1;
            if (ok) begin
                sent++;
                sValidBus = 1'b0;
            end
        end
        checkOutput("t3Sent", 64'(sent), 64'd1000);
        drain();

        $display("[TB] DEPTH=4 flush with concurrent push");
        sel       = 2;
        mReadyBus = 1'b0;
        applyStimulus(32'hB0, 1'b0, w);
        applyStimulus(32'hB1, 1'b0, w);
        applyStimulus(32'hB2, 1'b0, w);
        sDataBus  = 32'hBB;
        sLastBus  = 1'b1;
        sValidBus = 1'b1;
        invBus    = 1'b1;
        @(posedge clk);
        #1;
        invBus    = 1'b0;
        sValidBus = 1'b0;
        checkOutput("t4MValid", 64'(mValidV[2]), 64'd0);
        checkOutput("t4Count", 64'(countV[8:6]), 64'd0);
        checkOutput("t4SReady", 64'(sReadyV[2]), 64'd1);
        mReadyBus = 1'b1;
        applyStimulus(32'hCC, 1'b0, w);
        drain();

        $display("[TB] DEPTH=4 async reset mid-transfer");
        mReadyBus = 1'b0;
        applyStimulus(32'hD1, 1'b0, w);
        applyStimulus(32'hD2, 1'b0, w);
        sValidBus = 1'b0;
        @(negedge clk);
        #2;
        monEn = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("t5RstMValid", 64'(mValidV[2]), 64'd0);
        checkOutput("t5RstSReady", 64'(sReadyV[2]), 64'd0);
        checkOutput("t5RstCount", 64'(countV[8:6]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("t5SReadyLow", 64'(sReadyV[2]), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("t5SReadyUp", 64'(sReadyV[2]), 64'd1);
        checkOutput("t5MValid", 64'(mValidV[2]), 64'd0);
        monEn     = 1'b1;
        mReadyBus = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        drain();

        $display("[TB] DEPTH=2 full with pop and blocked push");
        sel       = 0;
        mReadyBus = 1'b0;
        applyStimulus(32'hE1, 1'b0, w);
        applyStimulus(32'hE2, 1'b0, w);
        checkOutput("t6FullSReady", 64'(sReadyV[0]), 64'd0);
        checkOutput("t6FullCount", 64'(countV[2:0]), 64'd2);
        sDataBus  = 32'hE3;
        sLastBus  = 1'b1;
        sValidBus = 1'b1;
        mReadyBus = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6SReady", 64'(sReadyV[0]), 64'd1);
        checkOutput("t6Count", 64'(countV[2:0]), 64'd1);
        applyStimulus(32'hE3, 1'b1, w);
        checkOutput("t6Wait", 64'(w), 64'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/axis_elastic_buffer.md
Name: axis_elastic_buffer

Overview:
Parametrised AXI-Stream elastic buffer. It is the multi-entry successor of the two-entry skid buffer and carries TDATA plus TLAST. It is used between pipeline stages where full throughput, registered TVALID/TREADY and a working flush (invalidate) are needed, e.g. fetch-to-decode after a branch redirect. It also exposes a fill-level output for backpressure/debug.

Parameters:
TDATA_WIDTH  32  payload width in bits; must be > 0
DEPTH  2  number of storage entries; must be >= 2
CNT_WIDTH  $clog2(DEPTH+1)  width of occupancy output; derived, not overridden

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
s_tvalid  input  1  upstream beat valid
s_tready  output  1  buffer can accept; registered
s_tdata  input  TDATA_WIDTH  upstream payload
s_tlast  input  1  upstream end-of-packet marker
m_tvalid  output  1  buffer holds a beat; registered
m_tready  input  1  downstream accepts
m_tdata  output  TDATA_WIDTH  head-entry payload
m_tlast  output  1  head-entry TLAST
invalidate  input  1  synchronous flush request
count  output  CNT_WIDTH  current number of stored entries

Behaviour:
- Elaboration: fatal if TDATA_WIDTH == 0 or DEPTH < 2.
- Storage: circular array of DEPTH entries ({tlast, tdata}), write pointer wr_ptr, read pointer rd_ptr, occupancy cnt (0..DEPTH). Pointers wrap DEPTH-1 -> 0, including non-power-of-2 DEPTH.
- Push = s_tvalid && s_tready. Pop = m_tvalid && m_tready.
- cnt_next = cnt + push - pop.
- m_tvalid is a register equal to (cnt != 0).
- m_tdata/m_tlast = entry at rd_ptr. Driven only from storage flops; no combinational path from s_* inputs.
- s_tready is a register loaded with (cnt_next < DEPTH). It has no combinational dependence on m_tready.
- count = cnt (registered).
- Latency: a beat pushed in cycle N is visible on m_* in cycle N+1 (minimum latency 1).
- Throughput: 1 beat/cycle sustained when upstream and downstream are both always ready/valid.
- Ordering: strict FIFO. Every pushed beat is delivered exactly once unless flushed. TLAST travels with its beat unchanged.
- Full (cnt == DEPTH): s_tready = 0.
  - A pop in that cycle makes s_tready = 1 in the next cycle.
  - No beat is ever dropped or overwritten.
- Empty (cnt == 0): m_tvalid = 0, and m_tdata holds a stale value (don't-care).
  - A push into empty gives m_tvalid = 1 next cycle; there is no bypass.
- Simultaneous push and pop at any 0 < cnt < DEPTH: cnt unchanged, both pointers advance.
- Once m_tvalid = 1, m_tdata/m_tlast stay stable until a pop or flush, per AXI-S rules.
- Flush (invalidate = 1 at a clock edge) has priority over push/pop:
  - Next cycle: cnt = 0, wr_ptr = rd_ptr = 0, m_tvalid = 0, s_tready = 1, count = 0.
  - A beat handshaked on s_* in the flush cycle is discarded.
  - A beat handshaked on m_* in the flush cycle is considered delivered.
  - invalidate held high for several cycles keeps the buffer empty. s_tready stays 1, so upstream beats are sunk and discarded.
- Reset (rst_n low, any time including mid-transfer):
  - Asynchronously: m_tvalid = 0, s_tready = 0, count = 0, pointers = 0, storage = 0.
  - s_tready rises to 1 on the first clk edge after rst_n deasserts.
- Storage payload flops need no reset for function, but they are reset to 0 to keep simulation X-free.

Test Plan:
- DEPTH=2, m_tready=1, push 0x11, 0x22, 0x33 (tlast on 0x33) back-to-back -> m_* shows 0x11, 0x22, 0x33 in consecutive cycles starting 1 cycle after the first push; m_tlast=1 only with 0x33; s_tready stays 1.
- DEPTH=4, m_tready=0, push 6 beats 0xA0..0xA5 -> exactly 0xA0..0xA3 accepted; s_tready=0 from the cycle after the 4th push; count=4. Then raise m_tready -> 0xA0..0xA5 delivered in order, none lost or duplicated.
- DEPTH=3 (non-power-of-2), random s_tvalid/m_tready at 50% for 1000 beats -> scoreboard order exact; count matches pushes minus pops every cycle; m_tdata stable while m_tvalid && !m_tready.
- DEPTH=4 holding 3 beats, assert invalidate one cycle while s_tvalid=1 with 0xBB -> next cycle m_tvalid=0, count=0, s_tready=1; 0xBB never appears on m_*. The next pushed 0xCC emerges first.
- Assert rst_n low for 1 cycle while count=2 and m_tvalid=1 -> m_tvalid=0, s_tready=0 immediately; s_tready=1 on the first edge after release; no stale beat is delivered afterwards.
- Full DEPTH=2 with push and pop in the same cycle (s_tready=0 at that point) -> no push accepted that cycle; next cycle s_tready=1 and count=1.
